// File: rtl/speed_pkg.sv
// Shared types and default constants for the game-speed tick generator.
package speed_pkg;

  localparam int unsigned LEVEL_W              = 3;
  localparam int unsigned BASE_HALF_DEF        = 12_500_000;
  localparam int unsigned BOOST_PERIODS_DEF    = 16;
  localparam int unsigned COOLDOWN_PERIODS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BOOST    = 2'd1,
    COOLDOWN = 2'd2
  } boost_state_t;

  // Larger of two unsigned constants, used for counter sizing.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/speed_tick_gen_if.sv
// Level/boost request inputs and rate/boost status outputs of the tick generator.
interface speed_tick_gen_if;

  logic [speed_pkg::LEVEL_W-1:0] level;
  logic                          boost_req;
  logic                          speed_out;
  logic                          tick;
  logic                          boost_en;
  logic                          boost_ready;

  modport master (
    output level, boost_req,
    input  speed_out, tick, boost_en, boost_ready
  );

  modport slave (
    input  level, boost_req,
    output speed_out, tick, boost_en, boost_ready
  );

endinterface

// File: rtl/speed_divider.sv
// Level-controlled clock divider producing a flop-driven square wave and a rise tick.
module speed_divider
  import speed_pkg::*;
#(
  parameter int unsigned BASE_HALF = BASE_HALF_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] level,
  output logic               speed_out,
  output logic               tick
);

  // Half-period is stored minus one so BASE_HALF itself never needs an extra bit.
  localparam int unsigned CNT_W = $clog2(BASE_HALF);

  // Half-period minus one for a given level; never below a one-cycle half period.
  function automatic logic [CNT_W-1:0] half_m1_of(input logic [LEVEL_W-1:0] lvl);
    int unsigned h;
    h = BASE_HALF >> lvl;
    if (h == 0) h = 1;
    return CNT_W'(h - 1);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1_q;
  logic [CNT_W-1:0] half_m1_live;
  logic [CNT_W-1:0] half_m1_eff;
  logic             armed;
  logic             wrap_c;

  // Until the first edge after reset the live level defines the half period.
  always_comb begin
    half_m1_live = half_m1_of(level);
    half_m1_eff  = armed ? half_m1_q : half_m1_live;
    wrap_c       = (cnt == half_m1_eff);
  end

  // Counter, toggle flop and rise tick; level is only latched at toggle boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      half_m1_q <= '0;
      armed     <= 1'b0;
      speed_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      armed <= 1'b1;
      tick  <= 1'b0;
      if (wrap_c) begin
        cnt       <= '0;
        speed_out <= ~speed_out;
        tick      <= ~speed_out;
        half_m1_q <= half_m1_live;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (!armed) half_m1_q <= half_m1_live;
      end
    end
  end

endmodule

// File: rtl/speed_tick_gen.sv
// Game-speed rate source: level-controlled divider plus boost/cooldown timer.
module speed_tick_gen
  import speed_pkg::*;
#(
  parameter int unsigned BASE_HALF        = BASE_HALF_DEF,
  parameter int unsigned BOOST_PERIODS    = BOOST_PERIODS_DEF,
  parameter int unsigned COOLDOWN_PERIODS = COOLDOWN_PERIODS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  speed_tick_gen_if.slave  bus
);

  localparam int unsigned PCNT_W = $clog2(max_u(BOOST_PERIODS, COOLDOWN_PERIODS) + 1);

  logic              tick;
  boost_state_t      state, state_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;
  logic              boost_en_q;
  logic              boost_ready_q;

  speed_divider #(
    .BASE_HALF (BASE_HALF)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .level     (bus.level),
    .speed_out (bus.speed_out),
    .tick      (tick)
  );

  assign bus.tick        = tick;
  assign bus.boost_en    = boost_en_q;
  assign bus.boost_ready = boost_ready_q;

  // Boost next-state: requests only honoured in IDLE, phases measured in ticks.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    case (state)
      IDLE: begin
        if (bus.boost_req) begin
          state_nxt = BOOST;
          pcnt_nxt  = '0;
        end
      end
      BOOST: begin
        if (tick) begin
          if (pcnt == PCNT_W'(BOOST_PERIODS - 1)) begin
            state_nxt = COOLDOWN;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + PCNT_W'(1);
          end
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (pcnt == PCNT_W'(COOLDOWN_PERIODS - 1)) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + PCNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        pcnt_nxt  = '0;
      end
    endcase
  end

  // State, period count and status flops decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pcnt          <= '0;
      boost_en_q    <= 1'b0;
      boost_ready_q <= 1'b1;
    end else begin
      state         <= state_nxt;
      pcnt          <= pcnt_nxt;
      boost_en_q    <= (state_nxt == BOOST);
      boost_ready_q <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_speed_tick_gen.sv
// Randomized bench for speed_tick_gen against a toggle-schedule / ticks-remaining model.
module tb_speed_tick_gen;
  import speed_pkg::*;

  localparam int unsigned TB_BASE_HALF = 16;
  localparam int unsigned TB_BOOST     = 2;
  localparam int unsigned TB_COOL      = 3;

  logic clk;
  logic rst_n;

  speed_tick_gen_if bus();

  speed_tick_gen #(
    .BASE_HALF        (TB_BASE_HALF),
    .BOOST_PERIODS    (TB_BOOST),
    .COOLDOWN_PERIODS (TB_COOL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state: absolute edge numbers and ticks still to wait.
  int   m_edge;
  int   m_next;
  logic m_out;
  logic m_tick;
  int   m_mode;   // 0 idle, 1 boosting, 2 cooling down
  int   m_left;

  logic [LEVEL_W-1:0] cur_lvl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, m_edge, got, exp);
    end
  endtask

  function automatic int half_of(input logic [LEVEL_W-1:0] lvl);
    int h;
    h = int'(TB_BASE_HALF) / (1 << lvl);
    return (h < 1) ? 1 : h;
  endfunction

  // Drive one cycle of inputs, advance the model over the next edge, compare.
  task automatic step(input logic req, input logic [LEVEL_W-1:0] lvl);
    bus.boost_req = req;
    bus.level     = lvl;
    @(posedge clk);
    case (m_mode)
      0: if (req) begin m_mode = 1; m_left = TB_BOOST; end
      1: if (m_tick) begin
           m_left--;
           if (m_left == 0) begin m_mode = 2; m_left = TB_COOL; end
         end
      default: if (m_tick) begin
           m_left--;
           if (m_left == 0) m_mode = 0;
         end
    endcase
    m_edge++;
    m_tick = 1'b0;
    if (m_edge == m_next) begin
      m_out  = ~m_out;
      m_tick = m_out;
      m_next = m_edge + half_of(lvl);
    end
    #1;
    chk("speed_out",   32'(bus.speed_out),   32'(m_out));
    chk("tick",        32'(bus.tick),        32'(m_tick));
    chk("boost_en",    32'(bus.boost_en),    32'(m_mode == 1));
    chk("boost_ready", 32'(bus.boost_ready), 32'(m_mode == 0));
  endtask

  // Assert reset between edges, check immediate reset values, release at a falling edge.
  task automatic do_reset(input logic [LEVEL_W-1:0] lvl);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_speed_out",   32'(bus.speed_out),   32'd0);
    chk("rst_tick",        32'(bus.tick),        32'd0);
    chk("rst_boost_en",    32'(bus.boost_en),    32'd0);
    chk("rst_boost_ready", 32'(bus.boost_ready), 32'd1);
    bus.boost_req = 1'b0;
    bus.level     = lvl;
    cur_lvl       = lvl;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_edge = 0;
    m_out  = 1'b0;
    m_tick = 1'b0;
    m_mode = 0;
    m_left = 0;
    m_next = half_of(lvl);
  endtask

  int   first_rise;
  int   tog_edges[$];
  logic prev_out;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.boost_req = 1'b0;
    bus.level     = '0;
    cur_lvl       = '0;
    m_edge = 0; m_next = 0; m_out = 1'b0; m_tick = 1'b0; m_mode = 0; m_left = 0;

    // Level 0 from reset: rises at 16 and 48, falls at 32.
    do_reset(LEVEL_W'(0));
    first_rise = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, LEVEL_W'(0));
      if (bus.tick && first_rise == 0) first_rise = m_edge;
    end
    chk("first_rise_l0", 32'(first_rise), 32'd16);

    // Level 2 then level 0 after edge 2: toggles at 4 and 20, no runt.
    do_reset(LEVEL_W'(2));
    prev_out = 1'b0;
    tog_edges.delete();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, (i < 2) ? LEVEL_W'(2) : LEVEL_W'(0));
      if (bus.speed_out != prev_out) tog_edges.push_back(m_edge);
      prev_out = bus.speed_out;
    end
    chk("level_toggle_cnt", 32'(tog_edges.size()), 32'd2);
    if (tog_edges.size() >= 2) begin
      chk("level_toggle0", 32'(tog_edges[0]), 32'd4);
      chk("level_toggle1", 32'(tog_edges[1]), 32'd20);
    end

    // Level 3 boost with extra requests during boost and cooldown.
    do_reset(LEVEL_W'(3));
    for (int i = 0; i < 40; i++)
      step((i == 1) || (i == 4) || (i == 12) || (i == 15), LEVEL_W'(3));

    // Request coincident with a tick while idle (rise edges 2, 6, 10 at level 3).
    do_reset(LEVEL_W'(3));
    for (int i = 0; i < 40; i++)
      step(i == 6, LEVEL_W'(3));

    // Randomized levels, requests and occasional mid-run resets.
    do_reset(LEVEL_W'(1));
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0)
        do_reset(LEVEL_W'($urandom_range(0, 4)));
      if (m_edge > 0 && $urandom_range(0, 15) == 0)
        cur_lvl = LEVEL_W'($urandom_range(0, 4));
      step($urandom_range(0, 5) == 0, cur_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/speed_tick_gen.md
Name: speed_tick_gen

Overview:
Upstream rate source for the game-speed path. It divides the system clock into a glitch-free square wave, `speed_out`, whose rate is set by the current game level; `speed_out` drives the downstream speed-boost edge doubler.
It also runs the boost power-up timer. `boost_en` tells the consumer to select the doubled rate for a fixed number of periods, followed by a cooldown during which new boost requests are refused.

Parameters:
BASE_HALF, 12_500_000, half-period in clk cycles at level 0 (2 Hz at 50 MHz); must be >= 128
LEVEL_W, 3, width of level input; max level 2**LEVEL_W-1
BOOST_PERIODS, 16, number of speed_out rising edges boost_en stays high
COOLDOWN_PERIODS, 32, number of speed_out rising edges before boost may be re-armed
CNT_W, $clog2(BASE_HALF), half-period counter width

Ports:
clk  in  1  system clock (single clock domain)
rst_n  in  1  asynchronous, active-low reset
level  in  LEVEL_W  game level; larger value gives a faster rate
boost_req  in  1  single-cycle request pulse, synchronous to clk
speed_out  out  1  registered square wave fed to the edge doubler
tick  out  1  one-cycle pulse, high in the same cycle speed_out goes 0->1
boost_en  out  1  high while boost is active
boost_ready  out  1  high when a boost_req will be accepted (state IDLE)

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, speed_out=0, tick=0, boost_en=0, state=IDLE, boost_ready=1, period counter=0.
  - half_lat = BASE_HALF >> level, sampled at reset release.
  - Outputs take reset values immediately, with no clock edge required.
- Divider:
  - cnt increments every clk.
  - When cnt == half_lat-1: cnt<=0, speed_out toggles, and half_lat reloads from BASE_HALF >> level.
  - Each half period is exactly half_lat cycles, so the first rise occurs at the half_lat-th clk edge after reset release.
- Level changes are applied only at toggle boundaries, never mid-half-period, so there is no runt pulse.
- tick is registered and high for exactly one cycle, coincident with each 0->1 transition of speed_out. There is no tick on falling transitions.
- speed_out comes straight from a flop. Combinational logic must never drive it.
- Boost FSM states:
  - IDLE: boost_ready=1, boost_en=0. A boost_req moves the FSM to BOOST at the next edge and clears the period counter.
  - BOOST: boost_en=1, boost_ready=0. Counts ticks. On the BOOST_PERIODS-th tick, moves to COOLDOWN and clears the period counter. boost_en is low from the following cycle.
  - COOLDOWN: boost_en=0, boost_ready=0. Counts ticks. On the COOLDOWN_PERIODS-th tick, moves to IDLE.
- boost_en and boost_ready are decoded from registered state (Moore outputs).
- boost_req in BOOST or COOLDOWN is ignored and not queued.
- boost_req in IDLE in the same cycle as a tick is accepted. That tick is not counted toward BOOST_PERIODS.
- Level changes during BOOST do not alter the tick counts; they only change the wall-clock duration.
- The period counter width is $clog2(max(BOOST_PERIODS, COOLDOWN_PERIODS)+1).

Decomposition:
- Package speed_pkg holds:
  - the boost_state_t enum {IDLE, BOOST, COOLDOWN};
  - LEVEL_W;
  - default BASE_HALF, BOOST_PERIODS and COOLDOWN_PERIODS constants.
- One sub-module, speed_divider, contains the cnt/half_lat/speed_out/tick logic with inputs clk, rst_n and level.
- The top module instantiates speed_divider and holds the boost FSM.

Test Plan:
(All scenarios use BASE_HALF=16, BOOST_PERIODS=2, COOLDOWN_PERIODS=3.)
- Release rst_n with level=0 -> speed_out rises at cycle 16, falls at 32, rises at 48; tick is high only at cycles 16 and 48.
- level=2 (half=4), switch to level=0 at cycle 2 -> speed_out toggles at cycle 4, then next toggle at cycle 20 (16 later); no short pulse.
- level=3 (half=2), boost_req at cycle 1 -> boost_en=1 and boost_ready=0 from cycle 2; boost_en drops the cycle after the 2nd following tick; boost_ready returns the cycle after the 3rd subsequent tick.
- boost_req pulsed during BOOST and again during COOLDOWN -> no change to state, counts or timing versus the previous scenario.
- boost_req coincident with a tick in IDLE -> BOOST entered; that tick not counted, so boost_en spans 2 further ticks.
- Drop rst_n mid-BOOST between clk edges -> speed_out=0, boost_en=0, boost_ready=1 and tick=0 immediately; after release, first rise at half_lat cycles.
